// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: state, opcode, ALU-control and datapath-select encodings shared by the multicycle controller.
package riscv_mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_ERROR
    } state_t;

    typedef enum logic [1:0] {AO_ADD, AO_SUB, AO_RTYPE, AO_ITYPE} alu_op_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_SLTU = 3'd6;

    localparam logic [1:0] A_PC    = 2'd0;
    localparam logic [1:0] A_OLDPC = 2'd1;
    localparam logic [1:0] A_RS1   = 2'd2;

    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    localparam logic [1:0] R_ALUOUT = 2'd0;
    localparam logic [1:0] R_DATA   = 2'd1;
    localparam logic [1:0] R_ALURES = 2'd2;
    localparam logic [1:0] R_IMM    = 2'd3;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // funct3[2] selects the lt/ltu pair, funct3[0] inverts the base condition
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic lt, input logic ltu);
        return f3[2] ? ((f3[1] ? ltu : lt) ^ f3[0]) : (!f3[1] && (zero ^ f3[0]));
    endfunction
endpackage

// File: rtl/riscv_alu_decoder.sv
// riscv_alu_decoder: maps the controller's ALU operation class plus funct3/funct7b5 to alu_control.
module riscv_alu_decoder
    import riscv_mc_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);
    logic [2:0] fn;

    // funct7b5 only means subtract for register-register ops; addi ignores it
    always_comb begin
        case (funct3)
            3'b000:  fn = (alu_op == AO_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  fn = ALU_SLT;
            3'b011:  fn = ALU_SLTU;
            3'b100:  fn = ALU_XOR;
            3'b110:  fn = ALU_OR;
            3'b111:  fn = ALU_AND;
            default: fn = ALU_ADD;
        endcase
        alu_control = alu_op == AO_ADD ? ALU_ADD : alu_op == AO_SUB ? ALU_SUB : fn;
    end
endmodule

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller: multicycle RV32 control FSM driving datapath enables and mux selects.
// Defining RISCV_MC_PERF_EN adds the cycle_count/instr_count performance counters.
module riscv_mc_controller
    import riscv_mc_pkg::*;
`ifdef RISCV_MC_PERF_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src,
    output logic       illegal
`ifdef RISCV_MC_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
`endif
);
    state_t  state, state_n;
    alu_op_t alu_op;
    logic    pc_w, ir_w, mem_w, reg_w;
    logic    st;

    // st remembers lw vs sw so MEMADR outputs depend on state, not on opcode
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            st    <= 1'b0;
        end else begin
            state <= state_n;
            st    <= state == S_DECODE ? opcode == OP_SW : st;
        end
    end

    always_comb begin
        state_n    = state;
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = A_RS1;
        alu_src_b  = B_IMM;
        result_src = R_ALUOUT;
        imm_src    = IMM_I;
        alu_op     = AO_ADD;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                ir_w       = 1'b1;
                pc_w       = 1'b1;
                alu_src_a  = A_PC;
                alu_src_b  = B_FOUR;
                result_src = R_ALURES;
                state_n    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = A_OLDPC;
                imm_src   = opcode == OP_SW ? IMM_S : opcode == OP_BR ? IMM_B :
                            opcode == OP_JAL ? IMM_J : opcode == OP_LUI ? IMM_U : IMM_I;
                case (opcode)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = S_EXECR;
                    OP_I:         state_n = S_EXECI;
                    OP_BR:        state_n = S_BRANCH;
                    OP_JAL:       state_n = S_JAL;
                    OP_JALR:      state_n = S_JALR;
                    OP_LUI:       state_n = S_LUI;
                    default:      state_n = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                imm_src = st ? IMM_S : IMM_I;
                state_n = st ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_n = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = R_DATA;
                reg_w      = 1'b1;
                state_n    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                state_n = S_FETCH;
            end
            S_EXECR: begin
                alu_src_b = B_RS2;
                alu_op    = AO_RTYPE;
                state_n   = S_ALUWB;
            end
            S_EXECI: begin
                alu_op  = AO_ITYPE;
                state_n = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w   = 1'b1;
                state_n = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b = B_RS2;
                alu_op    = AO_SUB;
                imm_src   = IMM_B;
                pc_w      = branch_taken(funct3, zero, lt, ltu);
                state_n   = S_FETCH;
            end
            // target already sits in ALUOut (from DECODE or JALR); ALU forms the link value
            S_JAL: begin
                alu_src_a = A_OLDPC;
                alu_src_b = B_FOUR;
                imm_src   = IMM_J;
                pc_w      = 1'b1;
                state_n   = S_ALUWB;
            end
            S_JALR:  state_n = S_JAL;
            S_LUI: begin
                result_src = R_IMM;
                imm_src    = IMM_U;
                reg_w      = 1'b1;
                state_n    = S_FETCH;
            end
            S_ERROR: illegal = 1'b1;
            default: state_n = S_FETCH;
        endcase
    end

    // reset holds the FSM in FETCH, so its enables must be masked while rst is high
    assign pc_write  = pc_w & ~rst;
    assign ir_write  = ir_w & ~rst;
    assign mem_write = mem_w & ~rst;
    assign reg_write = reg_w & ~rst;

    riscv_alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

`ifdef RISCV_MC_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            cycle_count <= cycle_count + CNT_W'(1);
            if (state_n == S_FETCH && state != S_FETCH)
                instr_count <= instr_count + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_riscv_mc_controller.sv
// tb_riscv_mc_controller: vector table, directed reset/illegal/counter sequences and a random
// instruction stream checked against a per-instruction latency model.
module tb_riscv_mc_controller;
    import riscv_mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = OP_LW;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0;
    logic       pc_write, ir_write, mem_write, reg_write, adr_src, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control, imm_src;
`ifdef RISCV_MC_PERF_EN
    logic [31:0] cycle_count, instr_count;
`endif
    logic [5:0] en;
    int         tests = 0, fails = 0;

    assign en = {pc_write, ir_write, mem_write, reg_write, adr_src, illegal};

    always #5 clk = ~clk;

    riscv_mc_controller dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .lt          (lt),
        .ltu         (ltu),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .adr_src     (adr_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .alu_control (alu_control),
        .imm_src     (imm_src),
        .illegal     (illegal)
`ifdef RISCV_MC_PERF_EN
        ,
        .cycle_count (cycle_count),
        .instr_count (instr_count)
`endif
    );

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, l, lu;
        int         cyc;
        logic [5:0] en;
        logic       chk_rs;
        logic [1:0] rs;
        logic       chk_alu;
        logic [2:0] alu;
    } vec_t;

    vec_t       vt [19];
    logic [6:0] legal [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("reset_quiet", 32'(en), 32'(0));
        tick();
        rst = 1'b0;
    endtask

    function automatic int lat(input logic [6:0] op);
        case (op)
            OP_LW, OP_JALR:    return 5;
            OP_SW, OP_R, OP_I: return 4;
            OP_JAL:            return 4;
            OP_BR, OP_LUI:     return 3;
            default:           return 0;
        endcase
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return l;
            3'd5:    return !l;
            3'd6:    return lu;
            3'd7:    return !lu;
            default: return 1'b0;
        endcase
    endfunction

    // expected {pc_write, ir_write, mem_write, reg_write, adr_src, illegal} in cycle c of an instruction
    function automatic logic [5:0] exp_en(input logic [6:0] op, input logic [2:0] f3,
                                          input logic z, input logic l, input logic lu, input int c);
        int   n;
        logic wb, pcw;
        n   = lat(op);
        wb  = op == OP_LW || op == OP_R || op == OP_I || op == OP_JAL || op == OP_JALR || op == OP_LUI;
        pcw = c == 1 || (op == OP_BR && c == 3 && taken(f3, z, l, lu)) ||
              ((op == OP_JAL || op == OP_JALR) && c == n - 1);
        return {pcw, c == 1, op == OP_SW && c == n, wb && c == n,
                (op == OP_LW || op == OP_SW) && c == 4, n == 0 && c >= 3};
    endfunction

    // bit 3 set means no defined expectation for this cycle
    function automatic logic [3:0] exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7, input int c);
        if (c == 1) return {1'b0, ALU_ADD};
        if (c == 3 && op == OP_BR) return {1'b0, ALU_SUB};
        if (c != 3 || !(op == OP_R || op == OP_I)) return 4'b1000;
        case (f3)
            3'd0:    return {1'b0, (op == OP_R && f7) ? ALU_SUB : ALU_ADD};
            3'd2:    return {1'b0, ALU_SLT};
            3'd3:    return {1'b0, ALU_SLTU};
            3'd4:    return {1'b0, ALU_XOR};
            3'd6:    return {1'b0, ALU_OR};
            3'd7:    return {1'b0, ALU_AND};
            default: return 4'b1000;
        endcase
    endfunction

    initial begin
        int cyc, ins;
        legal = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI};
        vt[0]  = '{OP_LW,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 6'b110000, 1'b1, R_ALURES, 1'b1, ALU_ADD};
        vt[1]  = '{OP_LW,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 6'b000000, 1'b0, R_ALUOUT, 1'b1, ALU_ADD};
        vt[2]  = '{OP_LW,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 6'b000010, 1'b0, R_ALUOUT, 1'b0, ALU_ADD};
        vt[3]  = '{OP_LW,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 6'b000100, 1'b1, R_DATA,   1'b0, ALU_ADD};
        vt[4]  = '{OP_R,    3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 6'b000000, 1'b0, R_ALUOUT, 1'b1, ALU_SUB};
        vt[5]  = '{OP_R,    3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 6'b000100, 1'b1, R_ALUOUT, 1'b0, ALU_ADD};
        vt[6]  = '{OP_BR,   3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 6'b100000, 1'b1, R_ALUOUT, 1'b1, ALU_SUB};
        vt[7]  = '{OP_BR,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 6'b000000, 1'b0, R_ALUOUT, 1'b1, ALU_SUB};
        vt[8]  = '{OP_LUI,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 6'b000100, 1'b1, R_IMM,    1'b0, ALU_ADD};
        vt[9]  = '{OP_SW,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 6'b001010, 1'b0, R_ALUOUT, 1'b0, ALU_ADD};
        vt[10] = '{OP_JAL,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 6'b100000, 1'b1, R_ALUOUT, 1'b1, ALU_ADD};
        vt[11] = '{OP_JAL,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 6'b000100, 1'b1, R_ALUOUT, 1'b0, ALU_ADD};
        vt[12] = '{OP_I,    3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3, 6'b000000, 1'b0, R_ALUOUT, 1'b1, ALU_XOR};
        vt[13] = '{OP_R,    3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 3, 6'b000000, 1'b0, R_ALUOUT, 1'b1, ALU_AND};
        vt[14] = '{OP_BR,   3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 3, 6'b100000, 1'b0, R_ALUOUT, 1'b0, ALU_ADD};
        vt[15] = '{OP_BR,   3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 3, 6'b000000, 1'b0, R_ALUOUT, 1'b0, ALU_ADD};
        vt[16] = '{OP_JALR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 6'b100000, 1'b1, R_ALUOUT, 1'b0, ALU_ADD};
        vt[17] = '{OP_JALR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 6'b000100, 1'b1, R_ALUOUT, 1'b0, ALU_ADD};
        vt[18] = '{OP_I,    3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 6'b000000, 1'b0, R_ALUOUT, 1'b1, ALU_ADD};

        for (int i = 0; i < 19; i++) begin
            opcode = vt[i].op; funct3 = vt[i].f3; funct7b5 = vt[i].f7;
            zero = vt[i].z; lt = vt[i].l; ltu = vt[i].lu;
            do_reset();
            repeat (vt[i].cyc - 1) tick();
            @(negedge clk);
            check($sformatf("vec%0d_en", i), 32'(en), 32'(vt[i].en));
            if (vt[i].chk_rs) check($sformatf("vec%0d_result_src", i), 32'(result_src), 32'(vt[i].rs));
            if (vt[i].chk_alu) check($sformatf("vec%0d_alu_control", i), 32'(alu_control), 32'(vt[i].alu));
        end

        // unsupported opcode: halt with illegal held until reset
        opcode = 7'b1111111;
        do_reset();
        repeat (2) tick();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("illegal_hold", 32'(en), 32'(6'b000001));
            tick();
        end
        do_reset();
        @(negedge clk);
        check("illegal_cleared_fetch", 32'(en), 32'(6'b110000));

        // reset while in MEMREAD: no write-back, FETCH right after release
        opcode = OP_LW;
        do_reset();
        repeat (3) tick();
        @(negedge clk);
        check("memread_adr", 32'(en), 32'(6'b000010));
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("midinstr_reset_quiet", 32'(en), 32'(0));
        rst = 1'b0;
        #1;
        check("midinstr_reset_fetch", 32'(en), 32'(6'b110000));
        tick();
        @(negedge clk);
        check("midinstr_reset_decode", 32'(en), 32'(0));

`ifdef RISCV_MC_PERF_EN
        do_reset();
        check("perf_cycle_reset", cycle_count, 32'd0);
        check("perf_instr_reset", instr_count, 32'd0);
        opcode = OP_SW;  repeat (4) tick();
        opcode = OP_LUI; repeat (3) tick();
        opcode = OP_JAL; repeat (4) tick();
        @(negedge clk);
        check("perf_instr_seq", instr_count, 32'd3);
        check("perf_cycle_seq", cycle_count, 32'd11);
`endif

        // random instruction stream against the latency model
        do_reset();
        cyc = 0;
        ins = 0;
        for (int k = 0; k < 300; k++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic [3:0] a;
            int         sel, n, nc;
            sel = $urandom_range(0, 9);
            op  = sel < 8 ? legal[sel] : 7'($urandom);
            while (sel >= 8 && lat(op) != 0) op = 7'($urandom);
            f3 = 3'($urandom);
            if (op == OP_BR && f3[2:1] == 2'b01) f3 = 3'd0;
            n  = lat(op);
            nc = n == 0 ? 6 : n;
            opcode = op; funct3 = f3; funct7b5 = 1'($urandom);
            for (int c = 1; c <= nc; c++) begin
                zero = 1'($urandom); lt = 1'($urandom); ltu = 1'($urandom);
                @(negedge clk);
                check($sformatf("rand%0d_op%b_c%0d_en", k, op, c), 32'(en),
                      32'(exp_en(op, f3, zero, lt, ltu, c)));
                a = exp_alu(op, f3, funct7b5, c);
                if (!a[3]) check($sformatf("rand%0d_c%0d_alu", k, c), 32'(alu_control), 32'(a[2:0]));
                tick();
                cyc++;
            end
            if (n == 0) begin
                do_reset();
                cyc = 0;
                ins = 0;
            end else begin
                ins++;
            end
        end
`ifdef RISCV_MC_PERF_EN
        @(negedge clk);
        check("perf_cycle_rand", cycle_count, 32'(cyc));
        check("perf_instr_rand", instr_count, 32'(ins));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
